// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared states, opcode constants and control-store address slice
//            for the multi-cycle instruction sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } seq_state_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  // Control-store address is {funct7[5], funct3, opcode}.
  function automatic logic [10:0] cs_addr_f(input logic [31:0] ir);
    return {ir[30], ir[14:12], ir[6:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_perf_cnt
// Purpose  : Free-running cycle and retired-instruction counters; present
//            only when SEQ_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef SEQ_PERF_CNT_EN
module seq_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cycle_en,
  input  logic             ret_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (cycle_en) r_cycle_cnt   <= r_cycle_cnt + 1'b1;
      if (ret_en)   r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule
`endif
`default_nettype wire

// File: rtl/instr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_seq_ctrl
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the
//            non-pipelined core. Optional counters: SEQ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_seq_ctrl
  import seq_pkg::*;
#(
  parameter int CTRL_BITS = 16,
  parameter int ADDR_W    = 11,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 ir_we,
  output logic [ADDR_W-1:0]    cs_addr,
  input  logic [CTRL_BITS-1:0] cs_data,
  output logic [CTRL_BITS-1:0] ctrl_word,
  input  logic                 is_mul,
  output logic                 mul_start,
  input  logic                 mul_done,
  input  logic                 branch_taken,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 pc_src,
  output logic                 illegal,
`ifdef SEQ_PERF_CNT_EN
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt,
`endif
  output logic [2:0]           state_o
);

  seq_state_e           r_state;
  logic [10:0]          r_cs;
  logic [CTRL_BITS-1:0] r_ctrl;
  logic                 r_illegal;
  logic                 r_imem_req;
  logic                 r_dmem_req;
  logic                 r_dmem_we;
  logic                 r_mul_start;
  logic                 r_rf_we;
  logic                 r_wb_pc_we;

  logic [6:0]           w_op;
  logic                 w_legal;
  logic                 w_exec_done;
  logic                 w_br_pc_we;
  logic                 w_st_pc_we;

  assign w_op        = r_cs[6:0];
  assign w_legal     = (w_op == OP_R) || (w_op == OP_I) || (w_op == OP_LOAD) ||
                       (w_op == OP_STORE) || (w_op == OP_BRANCH);
  assign w_exec_done = !is_mul || mul_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RST;
      r_cs        <= '0;
      r_ctrl      <= '0;
      r_illegal   <= 1'b0;
      r_imem_req  <= 1'b0;
      r_dmem_req  <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_mul_start <= 1'b0;
      r_rf_we     <= 1'b0;
      r_wb_pc_we  <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      r_rf_we     <= 1'b0;
      r_wb_pc_we  <= 1'b0;
      case (r_state)
        ST_RST: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_cs       <= cs_addr_f(instr);
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_legal) begin
            r_ctrl      <= cs_data;
            r_mul_start <= is_mul;
            r_state     <= ST_EXEC;
          end else begin
            r_ctrl    <= '0;
            r_illegal <= 1'b1;
            r_state   <= ST_TRAP;
          end
        end
        ST_EXEC: begin
          if (w_exec_done) begin
            if (w_op == OP_BRANCH) begin
              r_state    <= ST_FETCH;
              r_imem_req <= 1'b1;
            end else if ((w_op == OP_LOAD) || (w_op == OP_STORE)) begin
              r_state    <= ST_MEM;
              r_dmem_req <= 1'b1;
              r_dmem_we  <= (w_op == OP_STORE);
            end else begin
              r_state    <= ST_WB;
              r_rf_we    <= 1'b1;
              r_wb_pc_we <= 1'b1;
            end
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (w_op == OP_STORE) begin
              r_state    <= ST_FETCH;
              r_imem_req <= 1'b1;
            end else begin
              r_state    <= ST_WB;
              r_rf_we    <= 1'b1;
              r_wb_pc_we <= 1'b1;
            end
          end
        end
        ST_WB: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        default: r_state <= ST_TRAP;
      endcase
    end
  end

  // Strobes qualified by same-cycle handshakes stay combinational so the
  // zero-wait latencies hold; all are gated by state and thus low in reset.
  assign w_br_pc_we = (r_state == ST_EXEC) && (w_op == OP_BRANCH) && w_exec_done;
  assign w_st_pc_we = (r_state == ST_MEM) && (w_op == OP_STORE) && dmem_ack;

  assign imem_req  = r_imem_req;
  assign ir_we     = (r_state == ST_FETCH) && imem_ack;
  assign cs_addr   = ADDR_W'(r_cs);
  assign ctrl_word = r_ctrl;
  assign mul_start = r_mul_start;
  assign dmem_req  = r_dmem_req;
  assign dmem_we   = r_dmem_we;
  assign rf_we     = r_rf_we;
  assign pc_we     = r_wb_pc_we || w_br_pc_we || w_st_pc_we;
  assign pc_src    = w_br_pc_we && branch_taken;
  assign illegal   = r_illegal;
  assign state_o   = r_state;

`ifdef SEQ_PERF_CNT_EN
  seq_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .cycle_en    ((r_state != ST_RST) && (r_state != ST_TRAP)),
    .ret_en      (pc_we),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instr_seq_ctrl
// Purpose  : Directed table-driven bench for instr_seq_ctrl plus hand-written
//            trap, reset-abort and (SEQ_PERF_CNT_EN) counter sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_seq_ctrl;

  localparam int CTRL_BITS = 16;
  localparam int ADDR_W    = 11;
  localparam int CNT_W     = 32;

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_TRAP  = 3'd6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [31:0]          instr = '0;
  logic                 imem_req, imem_ack = 1'b0, ir_we;
  logic [ADDR_W-1:0]    cs_addr;
  logic [CTRL_BITS-1:0] cs_data, ctrl_word;
  logic                 is_mul = 1'b0, mul_start, mul_done = 1'b0;
  logic                 branch_taken = 1'b0;
  logic                 dmem_req, dmem_we, dmem_ack = 1'b0;
  logic                 rf_we, pc_we, pc_src, illegal;
  logic [2:0]           state_o;
`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0]     cycle_cnt, instret_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Control-store model: an arbitrary but distinct word per address.
  function automatic logic [15:0] cs_model(input logic [10:0] a);
    return {a[4:0], a} ^ 16'h5A3C;
  endfunction
  assign cs_data = cs_model(cs_addr);

  instr_seq_ctrl #(
    .CTRL_BITS (CTRL_BITS),
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .ir_we        (ir_we),
    .cs_addr      (cs_addr),
    .cs_data      (cs_data),
    .ctrl_word    (ctrl_word),
    .is_mul       (is_mul),
    .mul_start    (mul_start),
    .mul_done     (mul_done),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .illegal      (illegal),
`ifdef SEQ_PERF_CNT_EN
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt),
`endif
    .state_o      (state_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic        is_mul;
    logic        taken;
    int          iwait;
    int          mwait;
    int          dwait;
    logic [10:0] exp_cs;
    int          exp_pc_cyc;
    logic        exp_pc_src;
    int          exp_rf;
    int          exp_ms;
    int          exp_dreq;
    logic        exp_dwe;
  } vec_t;

  typedef struct {
    int          pc_cyc;
    int          pc_cnt;
    logic        pc_src;
    int          rf_cnt;
    int          rf_cyc;
    int          ms_cnt;
    int          ms_cyc;
    int          dreq;
    logic        dwe;
    int          ir_cnt;
    int          clash;
    logic [10:0] cs;
    logic [15:0] ctrl;
    logic        trapped;
    logic        timeout;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one instruction from its first FETCH cycle (cycle 1) until pc_we,
  // TRAP, or the cycle budget, acting as imem / multiplier / dmem.
  task automatic run_instr(input logic [31:0] ins, input logic mul, input logic tk,
                           input int iw, input int mw, input int dw, output obs_t o);
    int fc, ec, mc;
    bit done;
    o = '{default: 0};
    fc = 0; ec = 0; mc = 0; done = 1'b0;
    instr = ins; is_mul = mul; branch_taken = tk;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      imem_ack = (state_o == S_FETCH) && (fc >= iw);
      mul_done = (state_o == S_EXEC) && (ec >= mw);
      dmem_ack = (state_o == S_MEM) && (mc >= dw);
      if (state_o == S_FETCH) fc++;
      if (state_o == S_EXEC)  ec++;
      if (state_o == S_MEM)   mc++;
      #1;
      if (state_o == S_DEC) o.cs = cs_addr;
      if (ir_we) o.ir_cnt++;
      if (ir_we && pc_we) o.clash++;
      if (dmem_req) o.dreq++;
      if (dmem_we) o.dwe = 1'b1;
      if (mul_start) begin o.ms_cnt++; o.ms_cyc = k; end
      if (rf_we) begin o.rf_cnt++; o.rf_cyc = k; end
      if (pc_we) begin
        o.pc_cnt++; o.pc_cyc = k; o.pc_src = pc_src; o.ctrl = ctrl_word; done = 1'b1;
      end
      if (state_o == S_TRAP) begin o.trapped = 1'b1; done = 1'b1; end
    end
    if (!done) o.timeout = 1'b1;
  endtask

  // Asserts reset with hostile inputs, checks the quiet state, then releases.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b1; dmem_ack = 1'b1; mul_done = 1'b1; branch_taken = 1'b1; is_mul = 1'b1;
    #1;
    check("rst_state", state_o, S_RST);
    check("rst_strobes", {imem_req, ir_we, mul_start, dmem_req, dmem_we, rf_we, pc_we, pc_src, illegal}, 0);
    check("rst_cs_addr", cs_addr, 0);
    check("rst_ctrl_word", ctrl_word, 0);
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0; mul_done = 1'b0; branch_taken = 1'b0; is_mul = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_exit_fetch", state_o, S_FETCH);
    check("rst_exit_imem_req", imem_req, 1);
  endtask

  vec_t vecs[10];
  obs_t o;
  int   mc, bad, aborted_pc;
  bit   reached;

  initial begin
    //             instr         mul   tk    iw mw dw  cs       pc  src  rf ms dreq dwe
    vecs[0] = '{32'h002081B3, 1'b0, 1'b0, 0, 0, 0, 11'h033, 4, 1'b0, 1, 0, 0, 1'b0}; // add
    vecs[1] = '{32'h002081B3, 1'b0, 1'b0, 2, 0, 0, 11'h033, 6, 1'b0, 1, 0, 0, 1'b0}; // add, slow imem
    vecs[2] = '{32'h0000A183, 1'b0, 1'b0, 0, 0, 2, 11'h103, 7, 1'b0, 1, 0, 3, 1'b0}; // lw, 3-cycle dmem
    vecs[3] = '{32'h0030A023, 1'b0, 1'b0, 0, 0, 0, 11'h123, 4, 1'b0, 0, 0, 1, 1'b1}; // sw
    vecs[4] = '{32'h00208463, 1'b0, 1'b1, 0, 0, 0, 11'h063, 3, 1'b1, 0, 0, 0, 1'b0}; // beq taken
    vecs[5] = '{32'h00209463, 1'b0, 1'b0, 0, 0, 0, 11'h0E3, 3, 1'b0, 0, 0, 0, 1'b0}; // bne not taken
    vecs[6] = '{32'h022081B3, 1'b1, 1'b0, 0, 4, 0, 11'h033, 8, 1'b0, 1, 1, 0, 1'b0}; // mul, done 5th cycle
    vecs[7] = '{32'h402081B3, 1'b0, 1'b0, 0, 0, 0, 11'h433, 4, 1'b0, 1, 0, 0, 1'b0}; // sub
    vecs[8] = '{32'h00500093, 1'b0, 1'b0, 0, 0, 0, 11'h013, 4, 1'b0, 1, 0, 0, 1'b0}; // addi
    vecs[9] = '{32'h022081B3, 1'b1, 1'b0, 0, 0, 0, 11'h033, 4, 1'b0, 1, 1, 0, 1'b0}; // mul, immediate done

    #2 rst_n = 1'b0;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i].instr, vecs[i].is_mul, vecs[i].taken,
                vecs[i].iwait, vecs[i].mwait, vecs[i].dwait, o);
      check($sformatf("v%0d_timeout", i), o.timeout, 0);
      check($sformatf("v%0d_cs_addr", i), o.cs, vecs[i].exp_cs);
      check($sformatf("v%0d_pc_we_cycle", i), o.pc_cyc, vecs[i].exp_pc_cyc);
      check($sformatf("v%0d_pc_we_count", i), o.pc_cnt, 1);
      check($sformatf("v%0d_pc_src", i), o.pc_src, vecs[i].exp_pc_src);
      check($sformatf("v%0d_rf_we_count", i), o.rf_cnt, vecs[i].exp_rf);
      check($sformatf("v%0d_mul_start_count", i), o.ms_cnt, vecs[i].exp_ms);
      check($sformatf("v%0d_dmem_req_cycles", i), o.dreq, vecs[i].exp_dreq);
      check($sformatf("v%0d_dmem_we", i), o.dwe, vecs[i].exp_dwe);
      check($sformatf("v%0d_ir_we_count", i), o.ir_cnt, 1);
      check($sformatf("v%0d_ir_pc_clash", i), o.clash, 0);
      check($sformatf("v%0d_ctrl_word", i), o.ctrl, cs_model(vecs[i].exp_cs));
      if (vecs[i].exp_rf == 1) check($sformatf("v%0d_rf_we_cycle", i), o.rf_cyc, vecs[i].exp_pc_cyc);
      if (vecs[i].exp_ms == 1) check($sformatf("v%0d_mul_start_cycle", i), o.ms_cyc, 3);
    end

    // Unsupported opcode: trap, sticky illegal, nothing further fetched.
    run_instr(32'h0000007F, 1'b0, 1'b0, 0, 0, 0, o);
    check("trap_entered", o.trapped, 1);
    check("trap_cs_addr", o.cs, 11'h07F);
    check("trap_no_pc_we", o.pc_cnt, 0);
    check("trap_illegal", illegal, 1);
    check("trap_ctrl_word", ctrl_word, 0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      imem_ack = 1'b1; dmem_ack = 1'b1;
      #1;
      if (imem_req || ir_we || pc_we || rf_we || dmem_req || (state_o != S_TRAP) || !illegal) bad++;
    end
    check("trap_terminal", bad, 0);
    do_reset();

    // Reset in the middle of a stalled store: no pc_we may escape.
    instr = 32'h0030A023; is_mul = 1'b0; branch_taken = 1'b0;
    mc = 0; reached = 1'b0; aborted_pc = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      @(negedge clk);
      imem_ack = (state_o == S_FETCH); dmem_ack = 1'b0; mul_done = 1'b0;
      if (state_o == S_MEM) mc++;
      #1;
      if (pc_we) aborted_pc++;
      if (mc == 2) reached = 1'b1;
    end
    check("abort_reached_mem", reached, 1);
    #2 rst_n = 1'b0; dmem_ack = 1'b1;
    #1;
    check("abort_state_rst", state_o, S_RST);
    check("abort_strobes", {pc_we, rf_we, dmem_req, dmem_we}, 0);
    check("abort_no_pc_we", aborted_pc, 0);
    @(negedge clk);
    dmem_ack = 1'b0; imem_ack = 1'b0; rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_refetch", state_o, S_FETCH);
    run_instr(32'h002081B3, 1'b0, 1'b0, 0, 0, 0, o);
    check("post_abort_pc_we_cycle", o.pc_cyc, 4);
    check("post_abort_rf_we_count", o.rf_cnt, 1);

`ifdef SEQ_PERF_CNT_EN
    do_reset();
    check("perf_cycle_rst", cycle_cnt, 0);
    check("perf_instret_rst", instret_cnt, 0);
    for (int i = 0; i < 3; i++) run_instr(32'h002081B3, 1'b0, 1'b0, 0, 0, 0, o);
    @(posedge clk);
    #1;
    check("perf_instret", instret_cnt, 3);
    check("perf_cycle", cycle_cnt, 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
